control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle control FSM that sequences the processor datapath: fetches a 16-bit instruction at the current PC, drives register-file read/write addresses and enables, issues the ALU operation, and handshakes with data memory for loads and stores. It sits between the instruction ROM, the 16×8 register file, the ALU and data memory. It is the single owner of the register-file write enable and the PC.

## Interface
- `NumRegs`, 16: register-file depth.
- `IndexWidth`, `$clog2(NumRegs)`: register index width.
- `PcWidth`, 3: PC width (8-entry instruction ROM).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution from PC 0; sampled only in IDLE or HALT.
- `instr_i`  in  16  ROM data at `pc_o`, combinational; `[15:12]` opcode, `[11:8]` rd, `[7:4]` rs1, `[3:0]` rs2.
- `pc_o`  out  PcWidth  current PC.
- `rf_raddr1_o` / `rf_raddr2_o`  out  IndexWidth  register-file read addresses (rs1/rs2).
- `rf_waddr_o`  out  IndexWidth  write address (rd).
- `rf_we_o`  out  1  register-file write enable, one-cycle pulse.
- `alu_op_o`  out  3  ALU operation: 0 pass, 1 add, 2 sub, 3 and, 4 or.
- `mem_req_o`  out  1  data-memory request; held until acknowledged.
- `mem_we_o`  out  1  1 = store, 0 = load; valid while `mem_req_o`.
- `mem_ack_i`  in  1  memory acknowledge; completes the request in the cycle it is seen high.
- `busy_o`  out  1  high in every state except IDLE and HALT.
- `halted_o`  out  1  high in HALT.
- `illegal_o`  out  1  sticky flag, set by an undefined opcode.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: `start` → FETCH with PC = 0.
- FETCH: latch `instr_i` into IR → DECODE.
- DECODE: drive `rf_raddr1_o`/`rf_raddr2_o` from IR → EXEC.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: rd ← rs1 op rs2.
  - 5 LD: rd ← mem[rs1].
  - 6 ST: mem[rs1] ← rs2.
  - 7 JMP: PC ← IR[2:0].
  - F HALT.
  - 8–E illegal: set `illegal_o`, then execute as NOP.
- EXEC transitions:
  - ALU ops → WB, with `alu_op_o` driven.
  - LD/ST → MEM.
  - NOP/illegal → FETCH, PC+1.
  - JMP → FETCH, PC = IR[2:0].
  - HALT → HALT.
- MEM: assert `mem_req_o`, with `mem_we_o` = (opcode==ST).
  - Hold until `mem_ack_i`.
  - On ack: LD → WB; ST → FETCH, PC+1.
- WB: `rf_we_o` = 1 for exactly one cycle, `rf_waddr_o` = rd, `alu_op_o` held.
  - LD uses `alu_op_o` = 0 (pass memory data).
  - → FETCH, PC+1.
- HALT: hold all outputs; `start` → FETCH with PC = 0 and `illegal_o` cleared.
- PC arithmetic is modulo 2^PcWidth; 7 + 1 wraps to 0.
- `rf_raddr*`, `rf_waddr_o` and `alu_op_o` are registered from IR and stable DECODE through WB.

## Timing
- Reset (async assert): state IDLE, PC 0, IR 0, all outputs 0, `illegal_o` 0.
- Reset deassertion is synchronised by the integrator; the block needs no recovery cycle.
- Reset mid-instruction aborts immediately: no `rf_we_o`, and `mem_req_o` drops in the same instant.
- Cycle counts from FETCH entry:
  - ALU op: 4 (FETCH, DECODE, EXEC, WB).
  - NOP/JMP: 3.
  - LD: 5 + N wait cycles.
  - ST: 4 + N wait cycles.
- `mem_ack_i` high on the first MEM cycle gives zero wait; `mem_ack_i` outside MEM is ignored.
- `start` while busy is ignored.
- `start` and a HALT decode in the same cycle: HALT wins; `start` must be re-asserted.
- `rf_we_o` never asserts outside WB and never on consecutive cycles.

## Structure
- Shared package `ctrl_pkg` holds:
  - `state_e`, `opcode_e` (4-bit), `alu_op_e` (3-bit).
  - Instruction field bit positions.
- One combinational sub-module, `instr_decoder`: IR → opcode class, rd/rs1/rs2, `alu_op`, illegal.
- FSM, PC and IR live in `control_sequencer`.

## Test plan
- ALU op: ROM[0] = ADD r3,r1,r2 (0x1312), pulse `start` → `rf_raddr1_o`=1 and `rf_raddr2_o`=2 from DECODE; `alu_op_o`=1; `rf_we_o` with `rf_waddr_o`=3 on cycle 4; `pc_o`=1 after.
- LD wait states: LD r4,[r5] (0x5450), `mem_ack_i` delayed 3 cycles → `mem_req_o` high 4 cycles with `mem_we_o`=0, then a single WB pulse to r4; ST 0x6067 gives no `rf_we_o`.
- JMP and wrap: ROM[7] = NOP and ROM[2] = JMP 5 (0x7005) → PC sequence 0,1,2,5,6,7,0.
- Halt and illegal: ROM[1] = 0x9000, ROM[2] = 0xF000 → `illegal_o` set at EXEC of PC 1; `halted_o`=1 and `busy_o`=0; a second `start` restarts at PC 0 with `illegal_o` cleared.
- Reset abort: assert `rst_n`=0 during MEM with `mem_req_o` high → all outputs 0 immediately; after release, state IDLE and `start` runs from PC 0.
- `start` while busy during an ADD → ignored; no PC change or extra `rf_we_o`.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and instruction-field layout for the control sequencer and its decoder.
package ctrl_pkg;

  localparam int InstrWidth = 16;
  localparam int FieldWidth = 4;

  localparam int OpcodeLsb = 12;
  localparam int RdLsb     = 8;
  localparam int Rs1Lsb    = 4;
  localparam int Rs2Lsb    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_LD   = 4'h5,
    OP_ST   = 4'h6,
    OP_JMP  = 4'h7,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4
  } alu_op_e;

  // Coarse instruction class; the FSM branches only on this.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_JMP,
    CLS_HALT
  } op_class_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits an instruction word into class,
// register indices and ALU operation, and flags undefined opcodes.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [InstrWidth-1:0] ir_i,
  output op_class_e             op_class_o,
  output logic [FieldWidth-1:0] rd_o,
  output logic [FieldWidth-1:0] rs1_o,
  output logic [FieldWidth-1:0] rs2_o,
  output alu_op_e               alu_op_o,
  output logic                  illegal_o
);

  logic [FieldWidth-1:0] opcode;

  assign opcode = ir_i[OpcodeLsb +: FieldWidth];
  assign rd_o   = ir_i[RdLsb     +: FieldWidth];
  assign rs1_o  = ir_i[Rs1Lsb    +: FieldWidth];
  assign rs2_o  = ir_i[Rs2Lsb    +: FieldWidth];

  always_comb begin
    op_class_o = CLS_NOP;
    alu_op_o   = ALU_PASS;
    illegal_o  = 1'b0;
    case (opcode)
      OP_NOP:  op_class_o = CLS_NOP;
      OP_ADD:  begin op_class_o = CLS_ALU; alu_op_o = ALU_ADD; end
      OP_SUB:  begin op_class_o = CLS_ALU; alu_op_o = ALU_SUB; end
      OP_AND:  begin op_class_o = CLS_ALU; alu_op_o = ALU_AND; end
      OP_OR:   begin op_class_o = CLS_ALU; alu_op_o = ALU_OR;  end
      OP_LD:   op_class_o = CLS_LD;
      OP_ST:   op_class_o = CLS_ST;
      OP_JMP:  op_class_o = CLS_JMP;
      OP_HALT: op_class_o = CLS_HALT;
      // 8..E execute as NOP but raise the illegal flag
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory handshake and
// register write-back; sole owner of the PC and register-file write enable.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int NumRegs    = 16,
  parameter int IndexWidth = $clog2(NumRegs),
  parameter int PcWidth    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [InstrWidth-1:0] instr_i,
  output logic [PcWidth-1:0]    pc_o,
  output logic [IndexWidth-1:0] rf_raddr1_o,
  output logic [IndexWidth-1:0] rf_raddr2_o,
  output logic [IndexWidth-1:0] rf_waddr_o,
  output logic                  rf_we_o,
  output logic [2:0]            alu_op_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  input  logic                  mem_ack_i,
  output logic                  busy_o,
  output logic                  halted_o,
  output logic                  illegal_o
);

  state_e                  state_q, state_d;
  logic [PcWidth-1:0]      pc_q, pc_d, pc_inc;
  logic [InstrWidth-1:0]   ir_q, ir_d;
  logic [IndexWidth-1:0]   rs1_q, rs2_q, rd_q;
  alu_op_e                 alu_op_q;
  op_class_e               cls_q;
  logic                    ill_insn_q;
  logic                    illegal_q, illegal_d;

  op_class_e               dec_cls;
  logic [FieldWidth-1:0]   dec_rd, dec_rs1, dec_rs2;
  alu_op_e                 dec_alu_op;
  logic                    dec_illegal;

  // Decoding the next IR lets every decoded field be a register that is
  // already valid in DECODE and then stays frozen until the next FETCH.
  assign ir_d = (state_q == ST_FETCH) ? instr_i : ir_q;

  instr_decoder u_decoder (
    .ir_i       (ir_d),
    .op_class_o (dec_cls),
    .rd_o       (dec_rd),
    .rs1_o      (dec_rs1),
    .rs2_o      (dec_rs2),
    .alu_op_o   (dec_alu_op),
    .illegal_o  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alu_op_q   <= ALU_PASS;
      cls_q      <= CLS_NOP;
      ill_insn_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      rs1_q      <= IndexWidth'(dec_rs1);
      rs2_q      <= IndexWidth'(dec_rs2);
      rd_q       <= IndexWidth'(dec_rd);
      alu_op_q   <= dec_alu_op;
      cls_q      <= dec_cls;
      ill_insn_q <= dec_illegal;
      illegal_q  <= illegal_d;
    end
  end

  assign pc_inc = pc_q + PcWidth'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_EXEC;
        // Set on entry to EXEC so the flag is visible during EXEC itself
        if (ill_insn_q) illegal_d = 1'b1;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_ALU:          state_d = ST_WB;
          CLS_LD, CLS_ST:   state_d = ST_MEM;
          CLS_JMP: begin
            state_d = ST_FETCH;
            pc_d    = ir_q[PcWidth-1:0];
          end
          CLS_HALT:         state_d = ST_HALT;
          default: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ack_i) begin
          if (cls_q == CLS_LD) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
      end
      ST_HALT: begin
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          illegal_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc_o        = pc_q;
  assign rf_raddr1_o = rs1_q;
  assign rf_raddr2_o = rs2_q;
  assign rf_waddr_o  = rd_q;
  assign alu_op_o    = alu_op_q;
  assign rf_we_o     = (state_q == ST_WB);
  assign mem_req_o   = (state_q == ST_MEM);
  assign mem_we_o    = (state_q == ST_MEM) && (cls_q == CLS_ST);
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted_o    = (state_q == ST_HALT);
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; the instruction ROM is
// modelled as a bench array addressed by pc_o.
module tb_control_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr_i;
  logic [2:0]  pc_o;
  logic [3:0]  rf_raddr1_o, rf_raddr2_o, rf_waddr_o;
  logic        rf_we_o;
  logic [2:0]  alu_op_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic        busy_o, halted_o, illegal_o;

  logic [15:0] rom [0:7];
  int checks;
  int failures;

  assign instr_i = rom[pc_o];

  control_sequencer #(.NumRegs(16), .PcWidth(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr_i     (instr_i),
    .pc_o        (pc_o),
    .rf_raddr1_o (rf_raddr1_o),
    .rf_raddr2_o (rf_raddr2_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_we_o     (rf_we_o),
    .alu_op_o    (alu_op_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_ack_i   (mem_ack_i),
    .busy_o      (busy_o),
    .halted_o    (halted_o),
    .illegal_o   (illegal_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
  endtask

  // Called 1 time unit after a rising edge; releases well before the next one.
  task automatic do_reset();
    start     = 1'b0;
    mem_ack_i = 1'b0;
    rst_n     = 1'b0;
    #2;
    rst_n     = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({pc_o, rf_raddr1_o, rf_raddr2_o, rf_waddr_o, rf_we_o, alu_op_o,
         mem_req_o, mem_we_o, busy_o, halted_o, illegal_o} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=pc%0d ra1=%0d ra2=%0d wa=%0d we=%b alu=%0d req=%b mwe=%b busy=%b halt=%b ill=%b required=all zero",
               pc_o, rf_raddr1_o, rf_raddr2_o, rf_waddr_o, rf_we_o, alu_op_o,
               mem_req_o, mem_we_o, busy_o, halted_o, illegal_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || pc_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_idle actual=busy%b pc%0d required=busy0 pc0", busy_o, pc_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    clear_rom();
    rom[0] = 16'h1312;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || pc_o !== 3'd0) begin
      failures++;
      $display("FAIL alu_fetch actual=busy%b pc%0d required=busy1 pc0", busy_o, pc_o);
    end
    tick();
    checks++;
    if (rf_raddr1_o !== 4'd1 || rf_raddr2_o !== 4'd2) begin
      failures++;
      $display("FAIL alu_decode_addr actual=%0d,%0d required=1,2", rf_raddr1_o, rf_raddr2_o);
    end
    tick();
    checks++;
    if (alu_op_o !== 3'd1 || rf_we_o !== 1'b0) begin
      failures++;
      $display("FAIL alu_exec actual=op%0d we%b required=op1 we0", alu_op_o, rf_we_o);
    end
    tick();
    checks++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 4'd3 || alu_op_o !== 3'd1) begin
      failures++;
      $display("FAIL alu_wb actual=we%b wa%0d op%0d required=we1 wa3 op1", rf_we_o, rf_waddr_o, alu_op_o);
    end
    tick();
    checks++;
    if (rf_we_o !== 1'b0 || pc_o !== 3'd1) begin
      failures++;
      $display("FAIL alu_after actual=we%b pc%0d required=we0 pc1", rf_we_o, pc_o);
    end
    $display("test_alu done");
  endtask

  task automatic test_start_busy();
    int we_cnt;
    int exp_pc;
    clear_rom();
    rom[0] = 16'h2312;
    do_reset();
    start = 1'b1;
    tick();
    we_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      exp_pc = (i < 4) ? 0 : 1;
      checks++;
      if (pc_o !== 3'(exp_pc)) begin
        failures++;
        $display("FAIL busy_start_pc cycle%0d actual=%0d required=%0d", i, pc_o, exp_pc);
      end
      if (i == 3) begin
        checks++;
        if (alu_op_o !== 3'd2 || rf_we_o !== 1'b1) begin
          failures++;
          $display("FAIL busy_start_wb actual=op%0d we%b required=op2 we1", alu_op_o, rf_we_o);
        end
      end
      if (rf_we_o) we_cnt++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (we_cnt != 1) begin
      failures++;
      $display("FAIL busy_start_we_count actual=%0d required=1", we_cnt);
    end
    $display("test_start_busy done");
  endtask

  task automatic test_ld_st();
    int req_cnt;
    int we_cnt;
    clear_rom();
    rom[0] = 16'h5450;
    rom[1] = 16'h6067;
    do_reset();
    mem_ack_i = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL ld_exec_req actual=%b required=0", mem_req_o);
    end
    mem_ack_i = 1'b0;
    tick();
    req_cnt = 0;
    we_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req_o && !mem_we_o) req_cnt++;
      if (rf_we_o) we_cnt++;
      if (i == 3) mem_ack_i = 1'b1;
      tick();
    end
    mem_ack_i = 1'b0;
    checks++;
    if (req_cnt != 4 || we_cnt != 0) begin
      failures++;
      $display("FAIL ld_wait actual=req%0d we%0d required=req4 we0", req_cnt, we_cnt);
    end
    checks++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 4'd4 || alu_op_o !== 3'd0 || mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL ld_wb actual=we%b wa%0d op%0d req%b required=we1 wa4 op0 req0",
               rf_we_o, rf_waddr_o, alu_op_o, mem_req_o);
    end
    tick();
    checks++;
    if (rf_we_o !== 1'b0 || pc_o !== 3'd1) begin
      failures++;
      $display("FAIL ld_after actual=we%b pc%0d required=we0 pc1", rf_we_o, pc_o);
    end
    tick();
    tick();
    tick();
    checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || rf_raddr1_o !== 4'd6 || rf_raddr2_o !== 4'd7) begin
      failures++;
      $display("FAIL st_mem actual=req%b mwe%b ra1=%0d ra2=%0d required=req1 mwe1 ra1=6 ra2=7",
               mem_req_o, mem_we_o, rf_raddr1_o, rf_raddr2_o);
    end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checks++;
    if (pc_o !== 3'd2 || mem_req_o !== 1'b0 || rf_we_o !== 1'b0) begin
      failures++;
      $display("FAIL st_after actual=pc%0d req%b we%b required=pc2 req0 we0", pc_o, mem_req_o, rf_we_o);
    end
    $display("test_ld_st done");
  endtask

  task automatic test_jmp_wrap();
    int exp_pc [7] = '{0, 1, 2, 5, 6, 7, 0};
    clear_rom();
    rom[2] = 16'h7005;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (pc_o !== 3'(exp_pc[k])) begin
        failures++;
        $display("FAIL jmp_pc step%0d actual=%0d required=%0d", k, pc_o, exp_pc[k]);
      end
      tick();
      tick();
      tick();
    end
    $display("test_jmp_wrap done");
  endtask

  task automatic test_halt_illegal();
    clear_rom();
    rom[1] = 16'h9000;
    rom[2] = 16'hF000;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (pc_o !== 3'd1 || illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL ill_decode actual=pc%0d ill%b required=pc1 ill0", pc_o, illegal_o);
    end
    tick();
    checks++;
    if (illegal_o !== 1'b1) begin
      failures++;
      $display("FAIL ill_exec actual=%b required=1", illegal_o);
    end
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (halted_o !== 1'b1 || busy_o !== 1'b0 || pc_o !== 3'd2 || illegal_o !== 1'b1) begin
      failures++;
      $display("FAIL halt_enter actual=halt%b busy%b pc%0d ill%b required=halt1 busy0 pc2 ill1",
               halted_o, busy_o, pc_o, illegal_o);
    end
    tick();
    checks++;
    if (halted_o !== 1'b1) begin
      failures++;
      $display("FAIL halt_hold actual=%b required=1", halted_o);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (halted_o !== 1'b0 || busy_o !== 1'b1 || pc_o !== 3'd0 || illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL halt_restart actual=halt%b busy%b pc%0d ill%b required=halt0 busy1 pc0 ill0",
               halted_o, busy_o, pc_o, illegal_o);
    end
    $display("test_halt_illegal done");
  endtask

  task automatic test_reset_abort();
    clear_rom();
    rom[0] = 16'h5450;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (mem_req_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_req actual=%b required=1", mem_req_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_o, rf_raddr1_o, rf_raddr2_o, rf_waddr_o, rf_we_o, alu_op_o,
         mem_req_o, mem_we_o, busy_o, halted_o, illegal_o} !== 25'd0) begin
      failures++;
      $display("FAIL abort_outputs actual=pc%0d ra1=%0d wa=%0d we=%b req=%b busy=%b required=all zero",
               pc_o, rf_raddr1_o, rf_waddr_o, rf_we_o, mem_req_o, busy_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || rf_we_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle actual=busy%b we%b required=busy0 we0", busy_o, rf_we_o);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || pc_o !== 3'd0) begin
      failures++;
      $display("FAIL abort_restart actual=busy%b pc%0d required=busy1 pc0", busy_o, pc_o);
    end
    $display("test_reset_abort done");
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    mem_ack_i = 1'b0;
    clear_rom();
    #3;
    test_reset();
    test_alu();
    test_start_busy();
    test_ld_st();
    test_jmp_wrap();
    test_halt_illegal();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
